// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth signed multiplier sequencer driving an external WIDTH+1 bit
// combinational adder/subtractor; one add/sub per non-trivial Booth pair.
module booth_mul_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH:0]       add_a,
   output logic [WIDTH:0]       add_b,
   output logic                 add_op,
   output logic                 add_cin,
   input  logic [WIDTH:0]       add_sum,
   input  logic                 add_cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              state_r;
   logic [WIDTH:0]      a_r;
   logic [WIDTH-1:0]    q_r;
   logic                q_m1_r;
   logic [WIDTH-1:0]    m_r;
   logic [CW-1:0]       count_r;
   logic [WIDTH:0]      shift_a_s;
   logic [WIDTH-1:0]    shift_q_s;
   logic                unused_cout_s;

   assign add_a         = a_r;
   assign add_b         = {m_r[WIDTH-1], m_r};
   assign add_cin       = 1'b0;
   assign unused_cout_s = add_cout;

   // Arithmetic right shift of the {A,Q} pair, A's sign bit replicated.
   always_comb begin
      shift_a_s = {a_r[WIDTH], a_r[WIDTH:1]};
      shift_q_s = {a_r[0], q_r[WIDTH-1:1]};
   end

   // Sequencer: state, datapath registers and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         a_r     <= '0;
         q_r     <= '0;
         q_m1_r  <= 1'b0;
         m_r     <= '0;
         count_r <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         add_op  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m_r     <= multiplicand;
                  q_r     <= multiplier;
                  a_r     <= '0;
                  q_m1_r  <= 1'b0;
                  count_r <= '0;
                  add_op  <= multiplier[0];
                  busy    <= 1'b1;
                  state_r <= LOAD;
               end else begin
                  busy    <= 1'b0;
               end
            end
            LOAD: begin
               add_op  <= q_r[0] & ~q_m1_r;
               state_r <= (q_r[0] ^ q_m1_r) ? ADD : SHIFT;
            end
            ADD: begin
               a_r     <= add_sum;
               state_r <= SHIFT;
            end
            SHIFT: begin
               a_r     <= shift_a_s;
               q_r     <= shift_q_s;
               q_m1_r  <= q_r[0];
               count_r <= count_r + CW'(1);
               // The pair after this shift is {old Q[1], old Q[0]}.
               add_op  <= q_r[1] & ~q_r[0];
               if (count_r == CW'(WIDTH - 1)) begin
                  product <= {shift_a_s[WIDTH-1:0], shift_q_s};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= (q_r[1] ^ q_r[0]) ? ADD : SHIFT;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed bench for booth_mul_ctrl with a behavioural adder/subtractor model.
module tb_booth_mul_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [15:0]   multiplicand;
   logic [15:0]   multiplier;
   logic          busy;
   logic          done;
   logic [31:0]   product;
   logic [16:0]   add_a;
   logic [16:0]   add_b;
   logic          add_op;
   logic          add_cin;
   logic [16:0]   add_sum;
   logic          add_cout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Adder model: op=1 means a-b.
   assign {add_cout, add_sum} = add_op ? ({1'b0, add_a} - {1'b0, add_b} + {17'd0, add_cin})
                                       : ({1'b0, add_a} + {1'b0, add_b} + {17'd0, add_cin});

   booth_mul_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .busy(busy), .done(done), .product(product),
      .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One multiplication; inj>0 pulses a competing start in that cycle.
   task automatic run(input string tag, input logic [15:0] m, input logic [15:0] q,
                      input logic [31:0] exp_p, input int exp_cyc, input int inj);
      logic [31:0] prev_p;
      int          seen;
      @(negedge clk);
      prev_p       = product;
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 0;
      for (int c = 1; c <= 60 && seen == 0; c++) begin
         @(negedge clk);
         if (c == inj) begin
            start        = 1'b1;
            multiplicand = 16'd7;
            multiplier   = 16'd7;
         end else if (c == inj + 1) begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1;
            check({tag, " done_cycle"}, c, exp_cyc);
            check({tag, " product"}, product, exp_p);
            check({tag, " busy_at_done"}, 32'(busy), 32'd0);
         end else begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " product_hold"}, product, prev_p);
         end
      end
      check({tag, " done_seen"}, seen, 32'd1);
      @(negedge clk);
      check({tag, " done_pulse_1cyc"}, 32'(done), 32'd0);
      check({tag, " product_after"}, product, exp_p);
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int late_done;
      rst          = 1'b1;
      start        = 1'b0;
      multiplicand = 16'd0;
      multiplier   = 16'd0;
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst product", product, 32'd0);
      check("rst add_op", 32'(add_op), 32'd0);
      check("rst add_a", 32'(add_a), 32'd0);
      check("rst add_b", 32'(add_b), 32'd0);
      check("rst add_cin", 32'(add_cin), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Start accepted but not sampled while idle low: no activity.
      @(negedge clk);
      check("idle busy", 32'(busy), 32'd0);

      run("t1", 16'd1034, 16'd526, 32'h00084C8C, 22, 0);
      check("t1 add_b sext", 32'(add_b), 32'h0000040A);
      run("t2", 16'hFFFF, 16'hFFFF, 32'h00000001, 19, 0);
      check("t2 add_b sext", 32'(add_b), 32'h0001FFFF);
      run("t3", 16'h8000, 16'h8000, 32'h40000000, 19, 0);
      run("t3b", 16'h8000, 16'h0001, 32'hFFFF8000, 20, 0);
      run("t4", 16'd1234, 16'd0, 32'h00000000, 18, 0);
      run("t5", 16'd3, 16'd5, 32'd15, 22, 5);
      run("t5b", 16'd7, 16'd7, 32'd49, 20, 0);

      // Reset in the middle of an operation.
      @(negedge clk);
      multiplicand = 16'd100;
      multiplier   = 16'hFFFD;
      start        = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      check("t6 busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("t6 rst busy", 32'(busy), 32'd0);
      check("t6 rst done", 32'(done), 32'd0);
      check("t6 rst product", product, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      late_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) late_done = 1;
      end
      check("t6 no_done", late_done, 32'd0);
      check("t6 idle busy", 32'(busy), 32'd0);
      run("t6b", 16'd100, 16'hFFFD, 32'hFFFFFED4, 21, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
